// File: rtl/sd_sector_responder_if.sv
// Sector-transfer bus between the initiator (core) and the sector responder,
// bundled with the responder's word-wide backing-store port.
interface sd_sector_responder_if #(
  parameter int SECT_BITS = 4
);
  // Initiator <-> responder
  logic [31:0]          sd_lba;
  logic                 sd_rd;
  logic                 sd_wr;
  logic                 sd_ack;
  logic [7:0]           sd_buff_addr;
  logic [15:0]          sd_buff_dout;
  logic                 sd_buff_wr;
  logic [15:0]          sd_buff_din;
  // Responder <-> backing store
  logic [SECT_BITS+7:0] mem_addr;
  logic                 mem_req;
  logic                 mem_we;
  logic [15:0]          mem_wdata;
  logic [15:0]          mem_rdata;
  logic                 mem_ack;

  // Responder view.
  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_rdata, mem_ack,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_addr, mem_req, mem_we, mem_wdata
  );

  // Environment view: the initiator plus the backing store.
  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_rdata, mem_ack,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_addr, mem_req, mem_we, mem_wdata
  );
endinterface

// File: rtl/sd_sector_responder.sv
// Responder end of the sector-transfer protocol used for backup-RAM
// save/load. Services one 256-word sector per request from a word-wide
// backing store behind a req/ack port. Sectors beyond the store are read as
// zeros and written into the void, with an oob pulse at the end.
module sd_sector_responder #(
  parameter int SECT_BITS = 4,
  parameter int ACK_LAT   = 3,
  parameter int DIN_LAT   = 2
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  sd_sector_responder_if.slave bus,
  output logic                 busy,
  output logic                 oob
);

  // One shared delay counter covers both the ack delay and the dpram wait.
  localparam int CNT_MAX = (ACK_LAT > DIN_LAT) ? ACK_LAT : DIN_LAT;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACKWAIT,
    S_RD_FETCH,
    S_RD_PUT,
    S_WR_ADDR,
    S_WR_WAIT,
    S_WR_STORE,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [7:0]           word_q;
  logic [SECT_BITS-1:0] lba_q;
  logic                 oor_q;        // captured sector is outside the store
  logic                 rd_q;         // 1 = read transfer, 0 = write transfer

  logic                 sd_ack_q;
  logic [7:0]           sd_buff_addr_q;
  logic [15:0]          sd_buff_dout_q;
  logic                 sd_buff_wr_q;
  logic [SECT_BITS+7:0] mem_addr_q;
  logic                 mem_req_q;
  logic                 mem_we_q;
  logic [15:0]          mem_wdata_q;
  logic                 busy_q;
  logic                 oob_q;

  logic [7:0]           word_d;
  logic                 req_seen;
  logic                 lba_oor;
  logic                 ack_lat_done;
  logic                 din_lat_done;
  logic                 last_word;
  logic                 mem_done;

  assign word_d       = word_q + 8'd1;
  assign req_seen     = bus.sd_rd | bus.sd_wr;
  assign lba_oor      = |bus.sd_lba[31:SECT_BITS];
  assign ack_lat_done = (cnt_q == CNT_W'(ACK_LAT - 1));
  assign din_lat_done = (cnt_q == CNT_W'(DIN_LAT - 1));
  assign last_word    = (word_q == 8'hFF);
  // Out-of-range sectors never touch memory, so they complete immediately.
  assign mem_done     = oor_q | bus.mem_ack;

  // Transfer sequencer with all outputs registered.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      word_q         <= '0;
      lba_q          <= '0;
      oor_q          <= 1'b0;
      rd_q           <= 1'b0;
      sd_ack_q       <= 1'b0;
      sd_buff_addr_q <= '0;
      sd_buff_dout_q <= '0;
      sd_buff_wr_q   <= 1'b0;
      mem_addr_q     <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_wdata_q    <= '0;
      busy_q         <= 1'b0;
      oob_q          <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch below sees the
      // register values from before this edge regardless of statement order.
      // NOTE: pulse outputs default low here; a branch that raises one holds
      // it for exactly one cycle without any explicit clear.
      sd_buff_wr_q <= 1'b0;
      oob_q        <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (req_seen) begin
            lba_q   <= bus.sd_lba[SECT_BITS-1:0];
            oor_q   <= lba_oor;
            rd_q    <= bus.sd_rd;      // read wins when both are raised
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_ACKWAIT;
          end
        end

        S_ACKWAIT: begin
          if (ack_lat_done) begin
            sd_ack_q <= 1'b1;
            word_q   <= 8'd0;
            cnt_q    <= '0;
            if (rd_q) begin
              mem_addr_q <= {lba_q, 8'd0};
              mem_we_q   <= 1'b0;
              mem_req_q  <= ~oor_q;
              state_q    <= S_RD_FETCH;
            end else begin
              sd_buff_addr_q <= 8'd0;
              state_q        <= S_WR_ADDR;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_RD_FETCH: begin
          if (mem_done) begin
            mem_req_q      <= 1'b0;
            sd_buff_addr_q <= word_q;
            sd_buff_dout_q <= oor_q ? 16'h0000 : bus.mem_rdata;
            sd_buff_wr_q   <= 1'b1;
            state_q        <= S_RD_PUT;
          end
        end

        S_RD_PUT: begin
          if (last_word) begin
            sd_ack_q <= 1'b0;
            busy_q   <= 1'b0;
            oob_q    <= oor_q;
            state_q  <= S_DONE;
          end else begin
            word_q     <= word_d;
            mem_addr_q <= {lba_q, word_d};
            mem_we_q   <= 1'b0;
            mem_req_q  <= ~oor_q;
            state_q    <= S_RD_FETCH;
          end
        end

        S_WR_ADDR: begin
          // sd_buff_addr already shows this word; start the dpram wait.
          cnt_q   <= '0;
          state_q <= S_WR_WAIT;
        end

        S_WR_WAIT: begin
          if (din_lat_done) begin
            mem_wdata_q <= bus.sd_buff_din;
            mem_addr_q  <= {lba_q, word_q};
            mem_we_q    <= ~oor_q;
            mem_req_q   <= ~oor_q;
            state_q     <= S_WR_STORE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_WR_STORE: begin
          if (mem_done) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (last_word) begin
              sd_ack_q <= 1'b0;
              busy_q   <= 1'b0;
              oob_q    <= oor_q;
              state_q  <= S_DONE;
            end else begin
              word_q         <= word_d;
              sd_buff_addr_q <= word_d;
              state_q        <= S_WR_ADDR;
            end
          end
        end

        S_DONE: begin
          // One guaranteed cycle with sd_ack low before the next capture.
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.sd_ack       = sd_ack_q;
  assign bus.sd_buff_addr = sd_buff_addr_q;
  assign bus.sd_buff_dout = sd_buff_dout_q;
  assign bus.sd_buff_wr   = sd_buff_wr_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign busy             = busy_q;
  assign oob              = oob_q;

endmodule

// File: tb/tb_sd_sector_responder.sv
// Bench for sd_sector_responder: backing-store model with fixed or random
// ack latency, a 2-cycle initiator dpram model, a scoreboard queue of
// expected read strobes / memory writes, a table of sector transfers and
// hand-written sequences for timing and mid-transfer reset.
module tb_sd_sector_responder;

  localparam int SECT_BITS = 4;
  localparam int ACK_LAT   = 3;
  localparam int DIN_LAT   = 2;
  localparam int AW        = SECT_BITS + 8;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] lba;
    bit          rand_lat;
    bit          fixed;       // write data = base + word instead of random
    logic [15:0] base;
    int          exp_strobes;
    int          exp_mem;
    int          exp_oob;
    int          exp_busy;    // busy-high cycles, 0 = not checked
  } vec_t;

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic oob;

  always #5 clk = ~clk;

  sd_sector_responder_if #(.SECT_BITS(SECT_BITS)) bus ();

  sd_sector_responder #(
    .SECT_BITS(SECT_BITS),
    .ACK_LAT  (ACK_LAT),
    .DIN_LAT  (DIN_LAT)
  ) dut (
    .clk_sys(clk),
    .reset  (reset),
    .bus    (bus),
    .busy   (busy),
    .oob    (oob)
  );

  logic [15:0] store     [0:(1<<AW)-1];
  logic [15:0] exp_store [0:(1<<AW)-1];
  logic [15:0] ibuf      [0:255];
  sb_t         sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_strobe, n_mem_ops, n_oob, n_busy, n_preack, sb_err;
  int first_wr_cyc, last_wr_cyc, ack_fall_cyc;
  int n_req_viol = 0;
  bit rand_lat_en = 1'b0;
  bit ack_prev    = 1'b0;

  always @(posedge clk) cyc++;

  // Backing store: acks a request after 1 (or 1..20 random) cycles.
  always @(posedge clk) begin : store_model
    int  mem_cnt;
    int  cur_lat;
    sb_t e;
    bus.mem_ack <= 1'b0;
    if (bus.mem_req === 1'b1 && bus.mem_ack !== 1'b1) begin
      if (mem_cnt == 0) cur_lat = rand_lat_en ? int'($urandom_range(20, 1)) : 1;
      mem_cnt++;
      if (mem_cnt >= cur_lat) begin
        mem_cnt = 0;
        bus.mem_ack <= 1'b1;
        n_mem_ops++;
        if (bus.mem_we) begin
          store[bus.mem_addr] = bus.mem_wdata;
          if (sb_q.size() == 0) sb_err++;
          else begin
            e = sb_q.pop_front();
            if (!e.is_wr || e.addr != bus.mem_addr || e.data != bus.mem_wdata) sb_err++;
          end
        end else begin
          bus.mem_rdata <= store[bus.mem_addr];
        end
      end
    end else if (bus.mem_req !== 1'b1) begin
      mem_cnt = 0;
    end
  end

  // Initiator dpram: data for sd_buff_addr appears two cycles later.
  logic [15:0] din_s1;
  always @(posedge clk) begin
    din_s1          <= ibuf[bus.sd_buff_addr];
    bus.sd_buff_din <= din_s1;
  end

  // Output monitor on the falling edge: read scoreboard and event counters.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (bus.sd_buff_wr === 1'b1) begin
      n_strobe++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      if (bus.sd_buff_addr == 8'hFF) last_wr_cyc = cyc;
      if (sb_q.size() == 0) sb_err++;
      else begin
        e = sb_q.pop_front();
        if (e.is_wr || e.addr != AW'(bus.sd_buff_addr) || e.data != bus.sd_buff_dout) sb_err++;
      end
    end
    if (oob === 1'b1) n_oob++;
    if (busy === 1'b1) n_busy++;
    if (busy === 1'b1 && bus.sd_ack !== 1'b1) n_preack++;
    if (ack_prev && bus.sd_ack !== 1'b1) ack_fall_cyc = cyc;
    ack_prev = (bus.sd_ack === 1'b1);
    if (bus.mem_req === 1'b1 && bus.sd_ack !== 1'b1) n_req_viol++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_counters();
    n_strobe     = 0;
    n_mem_ops    = 0;
    n_oob        = 0;
    n_busy       = 0;
    n_preack     = 0;
    sb_err       = 0;
    first_wr_cyc = -1;
    last_wr_cyc  = -1;
    ack_fall_cyc = -1;
  endtask

  function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] lba,
                              input bit rl, input int es, input int em,
                              input int eo, input int eb);
    vec_t v;
    v.rd = rd; v.wr = wr; v.lba = lba; v.rand_lat = rl;
    v.fixed = 1'b0; v.base = 16'h0000;
    v.exp_strobes = es; v.exp_mem = em; v.exp_oob = eo; v.exp_busy = eb;
    return v;
  endfunction

  // Request -> ack -> drop request -> wait for end; compare everything.
  task automatic run_transfer(input vec_t v, input string tag);
    bit            is_rd;
    bit            oor;
    int            guard;
    logic [AW-1:0] a;
    logic [15:0]   d;
    is_rd = v.rd;
    oor   = (v.lba >= 32'(1 << SECT_BITS));
    for (int w = 0; w < 256; w++) begin
      a = {v.lba[SECT_BITS-1:0], 8'(w)};
      if (is_rd) begin
        d = oor ? 16'h0000 : exp_store[a];
        sb_q.push_back('{is_wr: 1'b0, addr: AW'(w), data: d});
      end else begin
        d = v.fixed ? (v.base + 16'(w)) : 16'($urandom);
        ibuf[w] = d;
        if (!oor) begin
          sb_q.push_back('{is_wr: 1'b1, addr: a, data: d});
          exp_store[a] = d;
        end
      end
    end
    clear_counters();
    rand_lat_en = v.rand_lat;
    bus.sd_lba  = v.lba;
    bus.sd_rd   = v.rd;
    bus.sd_wr   = v.wr;
    guard = 0;
    do begin tick(); guard++; end while (bus.sd_ack !== 1'b1 && guard < 50);
    check({tag, "/ack_rise"}, 32'(bus.sd_ack), 32'd1);
    bus.sd_rd = 1'b0;
    bus.sd_wr = 1'b0;
    guard = 0;
    while (bus.sd_ack === 1'b1 && guard < 8000) begin tick(); guard++; end
    check({tag, "/ack_fall"}, 32'(bus.sd_ack), 32'd0);
    check({tag, "/busy_low_at_end"}, 32'(busy), 32'd0);
    tick();
    check({tag, "/ack_delay"}, n_preack, ACK_LAT);
    check({tag, "/strobes"}, n_strobe, v.exp_strobes);
    check({tag, "/mem_ops"}, n_mem_ops, v.exp_mem);
    check({tag, "/oob_pulses"}, n_oob, v.exp_oob);
    check({tag, "/sb_errors"}, sb_err, 0);
    check({tag, "/sb_left"}, sb_q.size(), 0);
    if (v.exp_busy != 0) check({tag, "/busy_cycles"}, n_busy, v.exp_busy);
    sb_q.delete();
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[$];
    vec_t v;
    int   guard;
    int   bad;
    logic [AW-1:0] a;

    // Transfer table: full save, full load, then corner cases.
    for (int s = 0; s < 16; s++) vecs.push_back(mk(1'b0, 1'b1, 32'(s), 1'b0, 0, 256, 0, 1283));
    for (int s = 0; s < 16; s++) vecs.push_back(mk(1'b1, 1'b0, 32'(s), 1'b0, 256, 256, 0, 771));
    vecs.push_back(mk(1'b1, 1'b0, 32'd16,         1'b0, 256,   0, 1, 515));
    vecs.push_back(mk(1'b0, 1'b1, 32'h8000_0003,  1'b0,   0,   0, 1, 1027));
    vecs.push_back(mk(1'b1, 1'b0, 32'd3,          1'b0, 256, 256, 0, 771));
    vecs.push_back(mk(1'b1, 1'b1, 32'd7,          1'b1, 256, 256, 0, 0));
    vecs.push_back(mk(1'b0, 1'b1, 32'd9,          1'b1,   0, 256, 0, 0));
    vecs.push_back(mk(1'b1, 1'b0, 32'd9,          1'b1, 256, 256, 0, 0));

    for (int i = 0; i < (1 << AW); i++) begin
      store[i]     = 16'hA500 + 16'(i);
      exp_store[i] = 16'hA500 + 16'(i);
    end
    for (int w = 0; w < 256; w++) ibuf[w] = 16'h0000;
    clear_counters();
    bus.sd_lba = 32'd0;
    bus.sd_rd  = 1'b0;
    bus.sd_wr  = 1'b0;
    reset      = 1'b1;
    repeat (3) tick();

    check("rst/sd_ack",       32'(bus.sd_ack),       32'd0);
    check("rst/sd_buff_wr",   32'(bus.sd_buff_wr),   32'd0);
    check("rst/mem_req",      32'(bus.mem_req),      32'd0);
    check("rst/mem_we",       32'(bus.mem_we),       32'd0);
    check("rst/busy",         32'(busy),             32'd0);
    check("rst/oob",          32'(oob),              32'd0);
    check("rst/sd_buff_addr", 32'(bus.sd_buff_addr), 32'd0);
    check("rst/sd_buff_dout", 32'(bus.sd_buff_dout), 32'd0);
    check("rst/mem_addr",     32'(bus.mem_addr),     32'd0);
    check("rst/mem_wdata",    32'(bus.mem_wdata),    32'd0);
    reset = 1'b0;
    tick();

    // Read lba 0 with 1-cycle store: data A500..A5FF, 3 cycles/word.
    run_transfer(mk(1'b1, 1'b0, 32'd0, 1'b0, 256, 256, 0, 771), "rd_lba0");
    check("rd_lba0/strobe_span",    last_wr_cyc - first_wr_cyc, 32'd765);
    check("rd_lba0/ack_fall_delay", ack_fall_cyc - last_wr_cyc, 32'd1);

    // Write lba 5 from a dpram holding 1000+w.
    v = mk(1'b0, 1'b1, 32'd5, 1'b0, 0, 256, 0, 1283);
    v.fixed = 1'b1;
    v.base  = 16'h1000;
    run_transfer(v, "wr_lba5");
    bad = 0;
    for (int w = 0; w < 256; w++) if (store[12'h500 + 12'(w)] !== 16'h1000 + 16'(w)) bad++;
    check("wr_lba5/store_contents", bad, 0);

    foreach (vecs[i]) run_transfer(vecs[i], $sformatf("vec%0d_lba%0h", i, vecs[i].lba));

    // Reset at word 100 of a write; data rewritten equals what is stored.
    for (int w = 0; w < 256; w++) begin
      a       = {4'd2, 8'(w)};
      ibuf[w] = exp_store[a];
      sb_q.push_back('{is_wr: 1'b1, addr: a, data: exp_store[a]});
    end
    clear_counters();
    rand_lat_en = 1'b0;
    bus.sd_lba  = 32'd2;
    bus.sd_wr   = 1'b1;
    guard = 0;
    do begin tick(); guard++; end while (bus.sd_ack !== 1'b1 && guard < 50);
    check("rst_mid/ack_rise", 32'(bus.sd_ack), 32'd1);
    bus.sd_wr = 1'b0;
    guard = 0;
    while (bus.sd_buff_addr !== 8'd100 && guard < 2000) begin tick(); guard++; end
    check("rst_mid/reach_word100", 32'(bus.sd_buff_addr), 32'd100);
    reset = 1'b1;
    tick();
    check("rst_mid/sd_ack",  32'(bus.sd_ack),  32'd0);
    check("rst_mid/mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mid/busy",    32'(busy),        32'd0);
    check("rst_mid/oob",     32'(oob),         32'd0);
    reset = 1'b0;
    repeat (4) tick();
    check("rst_mid/writes_done", n_mem_ops, 100);
    check("rst_mid/sb_errors",   sb_err,    0);
    check("rst_mid/busy_idle",   32'(busy), 32'd0);
    sb_q.delete();
    run_transfer(mk(1'b1, 1'b0, 32'd2, 1'b0, 256, 256, 0, 771), "rd_after_rst");

    check("mem_req_outside_ack", n_req_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
